lut_layer_sequencer: RTL and testbench

- Time-multiplexed evaluator for one LogicNets layer: NEURONS sparse LUT neurons share a single external synchronous-read truth-table memory.
- Per input vector, walks neuron index 0..NEURONS-1 and gathers each neuron's FANIN input fields through a programmable connectivity table.
- Issues one truth-table read per cycle, assembles the output activation vector and presents it on a valid/ready stream.
- Sits between the input feature stream and the next layer; replaces NEURONS parallel LUT instances.

---
 rtl/lut_layer_sequencer.sv | 137 +++++++++++++
 tb/tb_lut_layer_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed LogicNets layer: NEURONS LUT neurons share one synchronous-read truth-table memory.
// Optional LUTSEQ_OVERLAP_EN adds an output holding register so the next frame computes while the output waits.
module lut_layer_sequencer #(
   parameter int IN_FEATURES = 16,
   parameter int BW_IN       = 2,
   parameter int FANIN       = 4,
   parameter int NEURONS     = 20,
   parameter int BW_OUT      = 2
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      s_valid,
   output logic                                      s_ready,
   input  logic [IN_FEATURES*BW_IN-1:0]              s_data,
   input  logic                                      cfg_we,
   input  logic [$clog2(NEURONS)-1:0]                cfg_neuron,
   input  logic [$clog2(FANIN)-1:0]                  cfg_slot,
   input  logic [$clog2(IN_FEATURES)-1:0]            cfg_src,
   output logic                                      cfg_err,
   output logic                                      tt_en,
   output logic [$clog2(NEURONS)+FANIN*BW_IN-1:0]    tt_addr,
   input  logic [BW_OUT-1:0]                         tt_rdata,
   output logic                                      m_valid,
   input  logic                                      m_ready,
   output logic [NEURONS*BW_OUT-1:0]                 m_data,
   output logic                                      busy
);

   localparam int NW = $clog2(NEURONS);
   localparam int FW = $clog2(IN_FEATURES);
   localparam int AW = NW + FANIN*BW_IN;
   localparam int OW = NEURONS*BW_OUT;
   localparam logic [NW-1:0] LAST = NW'(NEURONS-1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;
   state_t r_state, w_state_nxt;

   logic [IN_FEATURES*BW_IN-1:0] r_in;
   logic [FW-1:0]                r_conn [NEURONS][FANIN];
   logic [NW-1:0]                r_idx, r_rd_idx;
   logic                         r_rd_pend;
   logic [OW-1:0]                r_out, w_out_nxt;
   logic [AW-1:0]                r_addr_last, w_addr;
   logic                         w_hs, w_cfg_ok;

`ifdef LUTSEQ_OVERLAP_EN
   logic [OW-1:0] r_hold;
   logic          r_hold_full;
`endif

   assign s_ready  = (r_state == S_IDLE);
   assign busy     = (r_state != S_IDLE);
   assign w_hs     = s_valid && s_ready;
   assign w_cfg_ok = (r_state == S_IDLE) && (32'(cfg_neuron) < NEURONS);
   assign cfg_err  = cfg_we && !w_cfg_ok;
   assign tt_en    = (r_state == S_RUN);
   assign tt_addr  = tt_en ? w_addr : r_addr_last;

   // Neuron index in the MSBs, slot k's gathered feature at [k*BW_IN +: BW_IN].
   always_comb begin
      w_addr = '0;
      w_addr[AW-1 -: NW] = r_idx;
      for (int k = 0; k < FANIN; k++)
         w_addr[k*BW_IN +: BW_IN] = r_in[r_conn[r_idx][k]*BW_IN +: BW_IN];
   end

   always_comb begin
      w_out_nxt = r_out;
      if (r_rd_pend) w_out_nxt[r_rd_idx*BW_OUT +: BW_OUT] = tt_rdata;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_hs) w_state_nxt = S_RUN;
         S_RUN:   if (r_idx == LAST) w_state_nxt = S_DRAIN;
`ifdef LUTSEQ_OVERLAP_EN
         S_DRAIN: if (!r_hold_full || m_ready) w_state_nxt = S_IDLE;
`else
         S_DRAIN: w_state_nxt = S_OUT;
`endif
         S_OUT:   if (m_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_in        <= '0;
         r_idx       <= '0;
         r_rd_idx    <= '0;
         r_rd_pend   <= 1'b0;
         r_out       <= '0;
         r_addr_last <= '0;
         for (int n = 0; n < NEURONS; n++)
            for (int k = 0; k < FANIN; k++)
               r_conn[n][k] <= FW'((n*FANIN + k) % IN_FEATURES);
      end else begin
         r_state   <= w_state_nxt;
         r_rd_pend <= (r_state == S_RUN);
         r_rd_idx  <= r_idx;
         r_out     <= w_out_nxt;
         if (r_state == S_RUN) begin
            r_idx       <= r_idx + 1'b1;
            r_addr_last <= w_addr;
         end
         if (w_hs) begin
            r_in  <= s_data;
            r_idx <= '0;
         end
         if (cfg_we && w_cfg_ok) r_conn[cfg_neuron][cfg_slot] <= cfg_src;
      end
   end

`ifdef LUTSEQ_OVERLAP_EN
   // Loading a new frame and draining the old one can coincide; the load wins and the flag stays set.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold      <= '0;
         r_hold_full <= 1'b0;
      end else if (r_state == S_DRAIN && w_state_nxt == S_IDLE) begin
         r_hold      <= w_out_nxt;
         r_hold_full <= 1'b1;
      end else if (m_ready) begin
         r_hold_full <= 1'b0;
      end
   end

   assign m_valid = r_hold_full;
   assign m_data  = r_hold;
`else
   assign m_valid = (r_state == S_OUT);
   assign m_data  = r_out;
`endif

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Randomized bench for lut_layer_sequencer against a frame-level reference model and a truth-table memory model.
module tb_lut_layer_sequencer;
   localparam int IN_FEATURES = 16, BW_IN = 2, FANIN = 4, NEURONS = 20, BW_OUT = 2;
   localparam int NW = 5, AW = 13, DW = 32, OW = 40;

   logic clk = 1'b0, rst = 1'b1;
   logic s_valid = 1'b0, s_ready;
   logic [DW-1:0] s_data = '0;
   logic cfg_we = 1'b0, cfg_err;
   logic [NW-1:0] cfg_neuron = '0;
   logic [1:0] cfg_slot = '0;
   logic [3:0] cfg_src = '0;
   logic tt_en;
   logic [AW-1:0] tt_addr;
   logic [BW_OUT-1:0] tt_rdata = '0;
   logic m_valid, m_ready = 1'b0, busy;
   logic [OW-1:0] m_data;

   int n_chk = 0, n_fail = 0;
   int tt_mode = 0;
   int run_cfg_k = 0;
   int mconn [NEURONS][FANIN];
   logic [AW-1:0] taddr [NEURONS];

   lut_layer_sequencer #(.IN_FEATURES(IN_FEATURES), .BW_IN(BW_IN), .FANIN(FANIN),
                         .NEURONS(NEURONS), .BW_OUT(BW_OUT)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .cfg_we(cfg_we), .cfg_neuron(cfg_neuron), .cfg_slot(cfg_slot), .cfg_src(cfg_src),
      .cfg_err(cfg_err), .tt_en(tt_en), .tt_addr(tt_addr), .tt_rdata(tt_rdata),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] tt_f(input logic [AW-1:0] a);
      logic [AW-1:0] h;
      if (tt_mode == 0) return a[1:0];
      h = AW'(a * 13) ^ (a >> 5) ^ (a >> 7);
      return h[1:0] ^ h[3:2];
   endfunction

   // Synchronous-read truth table; garbage when no read is issued.
   always @(posedge clk) tt_rdata <= tt_en ? tt_f(tt_addr) : 2'($urandom);

   function automatic logic [AW-1:0] exp_addr(input int n, input logic [DW-1:0] v);
      logic [AW-1:0] a;
      a = '0;
      a[AW-1 -: NW] = NW'(n);
      for (int k = 0; k < FANIN; k++) a[k*BW_IN +: BW_IN] = v[mconn[n][k]*BW_IN +: BW_IN];
      return a;
   endfunction

   function automatic logic [OW-1:0] model_out(input logic [DW-1:0] v);
      logic [OW-1:0] o;
      for (int n = 0; n < NEURONS; n++) o[n*BW_OUT +: BW_OUT] = tt_f(exp_addr(n, v));
      return o;
   endfunction

   task automatic model_reset();
      for (int n = 0; n < NEURONS; n++)
         for (int k = 0; k < FANIN; k++) mconn[n][k] = (n*FANIN + k) % IN_FEATURES;
   endtask

   task automatic run_frame(input logic [DW-1:0] v, input bit mr, input bit wcfg,
                            input int cn, input int cs, input int csrc, output logic [OW-1:0] got);
      logic [OW-1:0] exp;
      int cnt, vk;
      @(negedge clk);
      check("s_ready_idle", s_ready, 1);
      s_valid = 1; s_data = v; m_ready = mr;
      if (wcfg) begin
         cfg_we = 1; cfg_neuron = NW'(cn); cfg_slot = 2'(cs); cfg_src = 4'(csrc);
         if (cn < NEURONS) mconn[cn][cs] = csrc;
      end
      exp = model_out(v);
      cnt = 0; vk = 0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         s_valid = 0; cfg_we = 0;
         if (tt_en) begin
            if (cnt == 0) check("tt_first", k, 1);
            if (cnt < NEURONS) begin
               taddr[cnt] = tt_addr;
               check("tt_addr", tt_addr, exp_addr(cnt, v));
            end
            cnt++;
         end
         if (m_valid) begin vk = k; break; end
         if (k == run_cfg_k) begin
            cfg_we = 1; cfg_neuron = 3; cfg_slot = 1; cfg_src = 0;
            #1 check("cfg_err_run", cfg_err, 1);
         end
         if (run_cfg_k != 0 && k == run_cfg_k + 1) #1 check("cfg_err_pulse", cfg_err, 0);
      end
      check("tt_en_cnt", cnt, NEURONS);
      check("m_valid_lat", vk, NEURONS + 2);
      got = m_data;
      check("m_data", m_data, exp);
      if (mr) begin
         @(negedge clk);
         check("m_valid_drop", m_valid, 0);
         check("s_ready_back", s_ready, 1);
      end
   endtask

   initial begin
      logic [DW-1:0] v, vb;
      logic [OW-1:0] got, expc;
      int seen;
      // Reset
      @(negedge clk); @(negedge clk);
      rst = 0;
      check("rst_s_ready", s_ready, 1);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_tt_en", tt_en, 0);
      check("rst_tt_addr", tt_addr, 0);
      check("rst_cfg_err", cfg_err, 0);
      check("rst_busy", busy, 0);
      model_reset();

      // Directed: default connectivity, feature i = i[3:2] gives field n = n mod 4
      for (int i = 0; i < IN_FEATURES; i++) v[i*2 +: 2] = 2'(i >> 2);
      for (int n = 0; n < NEURONS; n++) expc[n*2 +: 2] = 2'(n % 4);
      run_frame(v, 1, 0, 0, 0, 0, got);
      check("dir_data", got, expc);
      check("tt_addr_hold", tt_addr, exp_addr(NEURONS-1, v));

      // Output held while m_ready is low
      run_frame($urandom, 0, 0, 0, 0, 0, got);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_valid", m_valid, 1);
         check("hold_data", m_data, got);
`ifdef LUTSEQ_OVERLAP_EN
         check("hold_s_ready", s_ready, 1);
`else
         check("hold_s_ready", s_ready, 0);
         check("hold_busy", busy, 1);
`endif
      end
      m_ready = 1;
      @(negedge clk);
      m_ready = 0;
      check("hold_release", m_valid, 0);

      // Connectivity write in IDLE: neuron 3 slot 1 <- feature 15
      @(negedge clk);
      cfg_we = 1; cfg_neuron = 3; cfg_slot = 1; cfg_src = 15;
      mconn[3][1] = 15;
      #1 check("cfg_ok_err", cfg_err, 0);
      @(negedge clk);
      cfg_we = 1; cfg_neuron = 20; cfg_slot = 0; cfg_src = 5;
      #1 check("cfg_range_err", cfg_err, 1);
      @(negedge clk);
      cfg_we = 0;
      #1 check("cfg_range_pulse", cfg_err, 0);
      v = $urandom; v[31:30] = 2'b11;
      run_cfg_k = 5;
      run_frame(v, 1, 0, 0, 0, 0, got);
      run_cfg_k = 0;
      check("n3_slot1", taddr[3][3:2], 2'b11);
      v = $urandom;
      run_frame(v, 1, 0, 0, 0, 0, got);
      check("n3_slot1_kept", taddr[3][3:2], v[31:30]);

      // Randomized frames with hashed truth table and same-cycle config writes
      tt_mode = 1;
      for (int f = 0; f < 10; f++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         run_frame($urandom, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 23),
                   $urandom_range(0, 3), $urandom_range(0, 15), got);
      end

      // Reset while idx = 7
      @(negedge clk);
      v = $urandom;
      s_valid = 1; s_data = v; m_ready = 1;
      @(negedge clk);
      s_valid = 0;
      repeat (7) @(negedge clk);
      check("mid_idx", tt_addr[AW-1 -: NW], 7);
      rst = 1;
      @(negedge clk);
      rst = 0;
      check("mid_tt_en", tt_en, 0);
      check("mid_m_valid", m_valid, 0);
      check("mid_s_ready", s_ready, 1);
      check("mid_busy", busy, 0);
      check("mid_m_data", m_data, 0);
      model_reset();
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (m_valid) seen++;
      end
      check("no_partial", seen, 0);
      tt_mode = 0;
      v = $urandom;
      run_frame(v, 1, 0, 0, 0, 0, got);
      check("n3_default", taddr[3][3:2], v[27:26]);

`ifdef LUTSEQ_OVERLAP_EN
      // Second frame stalls in DRAIN while the first waits in the holding register
      tt_mode = 1;
      v = $urandom; vb = $urandom;
      run_frame(v, 0, 0, 0, 0, 0, got);
      @(negedge clk);
      check("ov_s_ready", s_ready, 1);
      s_valid = 1; s_data = vb;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         s_valid = 0;
         if (tt_en) seen++;
      end
      check("ov_tt_cnt", seen, NEURONS);
      check("ov_stall_busy", busy, 1);
      check("ov_stall_tt_en", tt_en, 0);
      check("ov_first_data", m_data, model_out(v));
      m_ready = 1;
      @(negedge clk);
      m_ready = 0;
      check("ov_second_valid", m_valid, 1);
      check("ov_second_data", m_data, model_out(vb));
      check("ov_idle", busy, 0);
      m_ready = 1;
      @(negedge clk);
      m_ready = 0;
      check("ov_drain_out", m_valid, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
